// File: rtl/node_mem_ctrl.sv
// node_mem_ctrl: single-port SRAM front end. After reset it clears the
// first DEPTH words, then serves one read or write request at a time.
// Reads use a registered-address SRAM with one cycle of read latency,
// and the response is held until downstream takes it.
//
// Handshakes: a transfer happens on a rising edge where valid && ready
// are both 1. A producer keeps valid and its payload stable until that
// edge. A consumer may raise or lower ready freely. o_rsp_valid/o_rsp_data
// hold stable until the edge where i_rsp_ready is 1.
module node_mem_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_write,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_data,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic                  o_init_done,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_write,
    output logic [DATA_WIDTH-1:0] o_mem_data,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    output logic [2:0]            o_dbg_state
);

    // One extra bit lets the counter reach DEPTH, which marks the end of
    // the sweep even when DEPTH == 2**ADDR_WIDTH.
    localparam int CNT_W = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        INIT = 3'd0,
        IDLE = 3'd1,
        WR   = 3'd2,
        RD1  = 3'd3,
        RD2  = 3'd4,
        RSP  = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  init_done_q, init_done_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_write_q, mem_write_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;

    // State and every registered output; reset drops all of them at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            init_done_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_write_q <= 1'b0;
            mem_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            init_done_q <= init_done_d;
            mem_addr_q  <= mem_addr_d;
            mem_write_q <= mem_write_d;
            mem_data_q  <= mem_data_d;
        end
    end

    // Next state and next register values; everything holds unless changed.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        init_done_d = init_done_q;
        mem_addr_d  = mem_addr_q;
        mem_write_d = 1'b0;
        mem_data_d  = mem_data_q;
        case (state_q)
            INIT: begin
                if (cnt_q < CNT_W'(DEPTH)) begin
                    mem_addr_d  = cnt_q[ADDR_WIDTH-1:0];
                    mem_write_d = 1'b1;
                    mem_data_d  = '0;
                    cnt_d       = cnt_q + CNT_W'(1);
                end else begin
                    init_done_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            IDLE: begin
                if (i_req_valid) begin
                    mem_addr_d = i_req_addr;
                    if (i_req_write) begin
                        mem_data_d  = i_req_data;
                        mem_write_d = 1'b1;
                        state_d     = WR;
                    end else begin
                        state_d = RD1;
                    end
                end
            end
            // SRAM commits the write on this edge; no response follows.
            WR:  state_d = IDLE;
            // SRAM samples the address on this edge.
            RD1: state_d = RD2;
            RD2: begin
                rsp_data_d  = i_mem_data;
                rsp_valid_d = 1'b1;
                state_d     = RSP;
            end
            RSP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = INIT;
        endcase
    end

    assign o_req_ready = (state_q == IDLE);
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_init_done = init_done_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_write = mem_write_q;
    assign o_mem_data  = mem_data_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_node_mem_ctrl.sv
// Directed bench for node_mem_ctrl with a registered-read SRAM model.
module tb_node_mem_ctrl;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          init_done;
    logic [AW-1:0] mem_addr;
    logic          mem_write;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] mem_rdata;
    logic [2:0]    dbg_state;

    int n_cmp;
    int n_err;

    logic [DW-1:0] sram [16];

    node_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(16)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_write (req_write),
        .i_req_addr  (req_addr),
        .i_req_data  (req_data),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_data  (rsp_data),
        .o_init_done (init_done),
        .o_mem_addr  (mem_addr),
        .o_mem_write (mem_write),
        .o_mem_data  (mem_data),
        .i_mem_data  (mem_rdata),
        .o_dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM: write on the edge, registered read of the current address.
    initial begin
        for (int i = 0; i < 16; i++) sram[i] = 32'hBAD0_0000 | i;
    end
    always @(posedge clk) begin
        if (mem_write) sram[mem_addr] <= mem_data;
        mem_rdata <= sram[mem_addr];
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"}, 32'(req_ready), 32'd0);
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, " rsp_data"},  rsp_data, 32'd0);
        check({tag, " init_done"}, 32'(init_done), 32'd0);
        check({tag, " mem_addr"},  32'(mem_addr), 32'd0);
        check({tag, " mem_write"}, 32'(mem_write), 32'd0);
        check({tag, " mem_data"},  mem_data, 32'd0);
    endtask

    // Follows the clearing sweep; stop_at >= 0 returns right after that address.
    task automatic run_sweep(input int stop_at);
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("sweep%0d write", k), 32'(mem_write), 32'd1);
            check($sformatf("sweep%0d addr", k), 32'(mem_addr), 32'(k));
            check($sformatf("sweep%0d data", k), mem_data, 32'd0);
            check($sformatf("sweep%0d ready", k), 32'(req_ready), 32'd0);
            check($sformatf("sweep%0d done", k), 32'(init_done), 32'd0);
            if (k == stop_at) return;
        end
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("sweep end write", 32'(mem_write), 32'd0);
        check("sweep end done", 32'(init_done), 32'd1);
        check("sweep end ready", 32'(req_ready), 32'd1);
        check("sweep end rsp_valid", 32'(rsp_valid), 32'd0);
    endtask

    // Called at a negedge with the controller idle.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = a;
        req_data  = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("wr mem_write", 32'(mem_write), 32'd1);
        check("wr mem_addr", 32'(mem_addr), 32'(a));
        check("wr mem_data", mem_data, d);
        check("wr busy", 32'(req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("wr done write", 32'(mem_write), 32'd0);
        check("wr done ready", 32'(req_ready), 32'd1);
        check("wr no rsp", 32'(rsp_valid), 32'd0);
    endtask

    // Read with rsp_ready held low for 'hold' cycles once the response is up.
    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input int hold);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = a;
        req_data  = 32'h5555_5555;
        rsp_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rd mem_write", 32'(mem_write), 32'd0);
        check("rd mem_addr", 32'(mem_addr), 32'(a));
        check("rd e0 rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rd e1 rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rd e2 rsp_valid", 32'(rsp_valid), 32'd1);
        check("rd e2 rsp_data", rsp_data, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("rd hold rsp_valid", 32'(rsp_valid), 32'd1);
            check("rd hold rsp_data", rsp_data, exp);
            check("rd hold req_ready", 32'(req_ready), 32'd0);
            check("rd hold mem_write", 32'(mem_write), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rd end rsp_valid", 32'(rsp_valid), 32'd0);
        check("rd end req_ready", 32'(req_ready), 32'd1);
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Main sequence
    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        // Request held up all through the first sweep; it must be ignored.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 4'd3;
        req_data  = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        run_sweep(-1);

        do_write(4'd5, 32'hDEAD_BEEF);
        do_read(4'd5, 32'hDEAD_BEEF, 0);
        do_read(4'd9, 32'h0000_0000, 0);
        do_read(4'd5, 32'hDEAD_BEEF, 5);
        do_write(4'd15, 32'h1234_5678);
        do_write(4'd0, 32'hA5A5_A5A5);
        do_write(4'd15, 32'h0F0F_F0F0);
        do_read(4'd15, 32'h0F0F_F0F0, 0);
        do_read(4'd0, 32'hA5A5_A5A5, 1);

        // Reset while a response is waiting: it must vanish.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 4'd5;
        rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("pre-reset rsp_valid", 32'(rsp_valid), 32'd1);
        check("pre-reset rsp_data", rsp_data, 32'hDEAD_BEEF);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid-read reset");
        @(negedge clk);
        rsp_ready = 1'b1;
        rst_n = 1'b1;

        // Reset partway through the sweep, then a full sweep from 0.
        run_sweep(7);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid-sweep reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(-1);
        do_read(4'd5, 32'h0000_0000, 0);
        do_read(4'd15, 32'h0000_0000, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/node_mem_ctrl.md
NODE_MEM_CTRL -- requirements
Module: node_mem_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, SHALL set the node-address width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the node-word width.
REQ-003 Parameter DEPTH, default 16, SHALL set the number of words to initialise; DEPTH <= 2**ADDR_WIDTH is required.
REQ-004 i_clk  in  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 i_rst_n  in  1  SHALL be the asynchronous active-low reset.
REQ-006 i_req_valid  in  1  SHALL flag a valid upstream request.
REQ-007 o_req_ready  out  1  SHALL flag that the controller can accept a request.
REQ-008 i_req_write  in  1  SHALL select the operation: 1 = write, 0 = read.
REQ-009 i_req_addr  in  ADDR_WIDTH  SHALL carry the request word address.
REQ-010 i_req_data  in  DATA_WIDTH  SHALL carry the write data.
REQ-011 o_rsp_valid  out  1  SHALL flag valid read-response data.
REQ-012 i_rsp_ready  in  1  SHALL flag that downstream accepts the response.
REQ-013 o_rsp_data  out  DATA_WIDTH  SHALL carry the read-response data.
REQ-014 o_init_done  out  1  SHALL flag that the memory-clear sweep has finished.
REQ-015 o_mem_addr, o_mem_write, o_mem_data  out  ADDR_WIDTH/1/DATA_WIDTH  SHALL drive the SRAM address, write enable and write data, all registered.
REQ-016 i_mem_data  in  DATA_WIDTH  SHALL receive the SRAM read data.

Function
REQ-017 FSM states SHALL be INIT, IDLE, WR, RD1, RD2 and RSP.
REQ-018 INIT: each cycle, a counter SHALL drive o_mem_addr = count, o_mem_write = 1 and o_mem_data = 0, for count = 0..DEPTH-1.
REQ-019 After the write to DEPTH-1 has issued, the FSM SHALL go to IDLE and o_init_done SHALL go 1 and stay 1 until reset.
REQ-020 o_req_ready SHALL be 1 only in IDLE; a request is accepted on any edge where i_req_valid && o_req_ready.
REQ-021 Write accept (edge E0): register o_mem_addr = i_req_addr, o_mem_data = i_req_data, o_mem_write = 1; go to WR.
REQ-022 WR at edge E1: the SRAM performs the write; o_mem_write SHALL clear to 0; go to IDLE; no response is generated.
REQ-023 Read accept (edge E0): register o_mem_addr = i_req_addr, o_mem_write = 0; go to RD1.
REQ-024 RD1 at E1: the SRAM samples the address; go to RD2.
REQ-025 RD2 at E2: capture i_mem_data into o_rsp_data, set o_rsp_valid = 1, go to RSP.
REQ-026 RSP: o_rsp_valid and o_rsp_data SHALL hold stable until i_rsp_ready = 1; on that edge o_rsp_valid clears and the FSM returns to IDLE.
REQ-027 Minimum spacing SHALL be: write 2 cycles accept-to-accept; read 4 cycles with i_rsp_ready held high.
REQ-028 A read after a write to the same address SHALL return the written data.
REQ-029 Request inputs SHALL be ignored outside IDLE, including during INIT.
REQ-030 o_mem_write SHALL be 0 in IDLE, RD1, RD2 and RSP.

Reset
REQ-031 Asserting i_rst_n = 0 at any time, including mid-sweep or mid-read, SHALL immediately clear all of the following: state = INIT, counter = 0, o_req_ready = 0, o_rsp_valid = 0, o_rsp_data = 0, o_init_done = 0, o_mem_addr = 0, o_mem_write = 0, o_mem_data = 0.
REQ-032 Any response pending at reset SHALL be discarded.
REQ-033 The sweep SHALL restart from address 0 on the first rising edge after deassertion.

Verification
REQ-034 Init sweep: release reset with DEPTH = 16 -> o_mem_write = 1 for 16 consecutive cycles at addresses 0..15 with data 0, then o_init_done = 1 and o_req_ready = 1.
REQ-035 Write then read: write 0xDEADBEEF to address 5, then read address 5 -> o_rsp_valid rises two edges after read accept with o_rsp_data = 0xDEADBEEF.
REQ-036 Backpressure: read with i_rsp_ready = 0 for 5 cycles -> o_rsp_valid = 1 and data stable for all 5 cycles, o_req_ready = 0 throughout; response clears on the edge after i_rsp_ready = 1.
REQ-037 Post-init read: read address 9 with no prior write -> o_rsp_data = 0x00000000.
REQ-038 Reset mid-sweep: pull i_rst_n low at sweep address 7 -> outputs clear immediately; after release the sweep restarts at address 0 and completes all 16 writes.
REQ-039 Requests during INIT: i_req_valid = 1 throughout the sweep -> no request accepted, o_mem_data stays 0 until o_init_done = 1.
